// File: rtl/aes_block_sequencer.sv
// -----------------------------------------------------------------------------
// aes_block_sequencer
//
// Controller wrapped around the iterative AES round core. It accepts one
// 128-bit block at a time over a valid/ready handshake, latches the block,
// its direction and its key length, and pulses core_start for one cycle. While
// the core iterates, it serves core_round_key straight out of a 15-entry
// round-key store indexed by core_round. When the core reports idle again, it
// captures core_aes_out into a one-entry output buffer.
//
// Optional feature macro: AES_SEQ_TIMEOUT_EN
//   When defined, a RUN-cycle counter aborts a block that has not completed
//   within TIMEOUT_CYCLES RUN cycles. The abort drops the block, sets the
//   sticky timeout_err flag and returns the sequencer to IDLE.
//   When undefined, no counter is built, timeout_err is tied low and RUN
//   waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES : maximum RUN cycles before an abort (timeout build only)
//
// Ports:
//   clk, rst              clock (rising edge); synchronous active-high reset
//   key_wr_en/addr/data   round-key store write port (addr 15 is ignored)
//   key_wr_err            sticky flag: a key write arrived while busy
//   key_length            00/01 AES-128, 10 AES-192, 11 AES-256
//   in_valid/in_ready     block request handshake
//   in_data, in_encrypt   block and direction (1 = encrypt)
//   out_valid/out_ready   result handshake
//   out_data              result block
//   busy                  high whenever the sequencer is not IDLE
//   timeout_err           sticky abort flag
//   core_start            one-cycle start pulse to the round core
//   core_key_length       latched key length
//   core_encrypt_decrypt  latched direction
//   core_data             latched input block
//   core_round_key        combinational key_mem[core_round]; 0 above 14
//   core_valid            core idle and not started
//   core_round            round index requested by the core
//   core_aes_out          core result
// -----------------------------------------------------------------------------
module aes_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr_en,
  input  logic [3:0]   key_wr_addr,
  input  logic [127:0] key_wr_data,
  output logic         key_wr_err,
  input  logic [1:0]   key_length,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_encrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         timeout_err,
  output logic         core_start,
  output logic [1:0]   core_key_length,
  output logic         core_encrypt_decrypt,
  output logic [127:0] core_data,
  output logic [127:0] core_round_key,
  input  logic         core_valid,
  input  logic [3:0]   core_round,
  input  logic [127:0] core_aes_out
);

  localparam int DATA_W   = 128;
  localparam int KEY_ENTS = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] key_mem [0:KEY_ENTS-1];

  logic [DATA_W-1:0] blk_data_p0;
  logic              blk_enc_p0;
  logic [1:0]        blk_klen_p0;

  logic [DATA_W-1:0] res_data_p1;
  logic              vld_p1;

  logic              key_err_q;
  logic              accept;
  logic              capture;
  logic              abort;

  // Entry 15 does not exist; it reads back as zero.
  function automatic logic key_addr_ok(input logic [3:0] addr);
    return addr != 4'd15;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    core_start = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        // The buffer may be drained and refilled on the same edge.
        in_ready = !vld_p1 || out_ready;
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        if (core_valid) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else if (abort) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Optional RUN-cycle watchdog
  // ---------------------------------------------------------------------------
`ifdef AES_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] run_cnt;
  logic             timeout_q;

  // run_cnt holds the number of completed RUN cycles; the abort fires in the
  // RUN cycle that is the TIMEOUT_CYCLES-th one without core_valid.
  assign abort = (state == S_RUN) && !core_valid &&
                 (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_START) begin
        run_cnt <= '0;
      end else if (state == S_RUN && !abort) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-key store: writable only while IDLE, read combinationally by round
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_ENTS; i++) begin
        key_mem[i] <= '0;
      end
      key_err_q <= 1'b0;
    end else if (key_wr_en) begin
      if (state != S_IDLE) begin
        key_err_q <= 1'b1;
      end else if (key_addr_ok(key_wr_addr)) begin
        key_mem[key_wr_addr] <= key_wr_data;
      end
    end
  end

  assign key_wr_err = key_err_q;

  always_comb begin
    core_round_key = '0;
    if (key_addr_ok(core_round)) begin
      core_round_key = key_mem[core_round];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: block registers, stable from one accept to the next
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_data_p0 <= '0;
      blk_enc_p0  <= 1'b0;
      blk_klen_p0 <= 2'b00;
    end else if (accept) begin
      blk_data_p0 <= in_data;
      blk_enc_p0  <= in_encrypt;
      blk_klen_p0 <= key_length;
    end
  end

  assign core_data            = blk_data_p0;
  assign core_encrypt_decrypt = blk_enc_p0;
  assign core_key_length      = blk_klen_p0;

  // ---------------------------------------------------------------------------
  // Stage p1: one-entry output buffer
  // ---------------------------------------------------------------------------
  // Capture and drain never coincide: a block is only accepted once the
  // buffer is free or being drained, so it is empty again before capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (capture) begin
      res_data_p1 <= core_aes_out;
      vld_p1      <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign out_data  = res_data_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for aes_block_sequencer.
//
// A round-core stub folds every served round key into the block (XOR) and
// inverts the result for decrypt, so the result depends on exactly which
// key entries 0..Nr were served. A cycle-level behavioural model tracks the
// block timeline (busy for Nr+3 cycles after accept, result on Nr+4), the
// key store and the sticky flags, and is compared against the DUT on every
// cycle outside reset. Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_aes_block_sequencer;

  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_wr_en;
  logic [3:0]   key_wr_addr;
  logic [127:0] key_wr_data;
  logic         key_wr_err;
  logic [1:0]   key_length;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_encrypt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         timeout_err;
  logic         core_start;
  logic [1:0]   core_key_length;
  logic         core_encrypt_decrypt;
  logic [127:0] core_data;
  logic [127:0] core_round_key;
  logic         core_valid;
  logic [3:0]   core_round;
  logic [127:0] core_aes_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_block_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .key_wr_en           (key_wr_en),
    .key_wr_addr         (key_wr_addr),
    .key_wr_data         (key_wr_data),
    .key_wr_err          (key_wr_err),
    .key_length          (key_length),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .in_encrypt          (in_encrypt),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .busy                (busy),
    .timeout_err         (timeout_err),
    .core_start          (core_start),
    .core_key_length     (core_key_length),
    .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_data           (core_data),
    .core_round_key      (core_round_key),
    .core_valid          (core_valid),
    .core_round          (core_round),
    .core_aes_out        (core_aes_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nr_of(input logic [1:0] kl);
    return (kl == 2'b10) ? 12 : (kl == 2'b11) ? 14 : 10;
  endfunction

  // ---------------------------------------------------------------------------
  // Round-core stub
  // ---------------------------------------------------------------------------
  logic         stall;
  logic         force_en;
  logic [3:0]   force_val;
  logic         stub_run;
  logic [3:0]   stub_round;
  logic [127:0] stub_acc;
  logic [127:0] stub_out;

  always @(posedge clk) begin
    if (rst) begin
      stub_run   <= 1'b0;
      stub_round <= 4'd0;
      stub_acc   <= '0;
      stub_out   <= '0;
    end else if (!stub_run && core_start) begin
      stub_run   <= 1'b1;
      stub_round <= 4'd0;
      stub_acc   <= core_data;
    end else if (stub_run) begin
      if (stub_round == 4'(nr_of(core_key_length))) begin
        stub_run   <= 1'b0;
        stub_round <= 4'd0;
        stub_out   <= core_encrypt_decrypt ? (stub_acc ^ core_round_key)
                                           : ~(stub_acc ^ core_round_key);
      end else begin
        stub_acc   <= stub_acc ^ core_round_key;
        stub_round <= stub_round + 4'd1;
      end
    end
  end

  assign core_valid   = !stub_run && !stall;
  assign core_round   = force_en ? force_val : stub_round;
  assign core_aes_out = stub_out;

  // ---------------------------------------------------------------------------
  // Behavioural model and per-cycle compare
  // ---------------------------------------------------------------------------
  logic [127:0] m_key [0:14];
  logic         m_init   = 1'b0;
  logic         m_active = 1'b0;
  logic         m_ovld   = 1'b0;
  logic         m_kerr   = 1'b0;
  logic         m_terr   = 1'b0;
  logic         m_stalled = 1'b0;
  logic [127:0] m_odata  = '0;
  logic [127:0] m_exp    = '0;
  logic [127:0] m_bdata  = '0;
  logic         m_benc   = 1'b0;
  logic [1:0]   m_bkl    = 2'b00;
  int           cyc      = 0;
  int           m_s      = 0;
  int           m_end    = 0;

  function automatic logic [127:0] block_result(input logic [127:0] d, input logic enc,
                                                input logic [1:0] kl);
    logic [127:0] acc;
    acc = d;
    for (int r = 0; r <= nr_of(kl); r++) acc = acc ^ m_key[r];
    return enc ? acc : ~acc;
  endfunction

  always @(negedge clk) begin
    logic         e_ready;
    logic [127:0] e_rk;
    if (rst) begin
      for (int i = 0; i < 15; i++) m_key[i] = '0;
      m_init   = 1'b1;
      m_active = 1'b0;
      m_ovld   = 1'b0;
      m_kerr   = 1'b0;
      m_terr   = 1'b0;
      m_odata  = '0;
      m_bdata  = '0;
      m_benc   = 1'b0;
      m_bkl    = 2'b00;
    end else if (m_init) begin
      e_ready = !m_active && (!m_ovld || out_ready);
      e_rk    = (core_round <= 4'd14) ? m_key[core_round] : '0;
      chk("busy", busy, m_active);
      chk("in_ready", in_ready, e_ready);
      chk("core_start", core_start, m_active && (cyc == m_s + 1));
      chk("out_valid", out_valid, m_ovld);
      chk("out_data", out_data, m_odata);
      chk("key_wr_err", key_wr_err, m_kerr);
      chk("timeout_err", timeout_err, m_terr);
      chk("core_data", core_data, m_bdata);
      chk("core_encrypt_decrypt", core_encrypt_decrypt, m_benc);
      chk("core_key_length", core_key_length, m_bkl);
      chk("core_round_key", core_round_key, e_rk);
      // Advance the model across the coming clock edge.
      if (key_wr_en) begin
        if (m_active) m_kerr = 1'b1;
        else if (key_wr_addr != 4'd15) m_key[key_wr_addr] = key_wr_data;
      end
      if (m_ovld && out_ready) m_ovld = 1'b0;
      if (m_active && (cyc + 1 == m_end)) begin
        m_active = 1'b0;
        if (m_stalled) m_terr = 1'b1;
        else begin
          m_ovld  = 1'b1;
          m_odata = m_exp;
        end
      end
      if (in_valid && e_ready) begin
        m_active  = 1'b1;
        m_s       = cyc;
        m_bdata   = in_data;
        m_benc    = in_encrypt;
        m_bkl     = key_length;
        m_stalled = stall;
        m_end     = stall ? cyc + TO + 2 : cyc + nr_of(key_length) + 4;
        m_exp     = block_result(in_data, in_encrypt, key_length);
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic kw(input logic [3:0] a, input logic [127:0] d);
    key_wr_en   = 1'b1;
    key_wr_addr = a;
    key_wr_data = d;
    sync();
    key_wr_en   = 1'b0;
  endtask

  // Returns at posedge+1 of cycle 1 (START) of the accepted block.
  task automatic send(input logic [127:0] d, input logic enc, input logic [1:0] kl);
    int k;
    k = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_encrypt = enc;
    key_length = kl;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_wait: in_ready got 0 expected 1 within 200 cycles");
    end
    sync();
    in_valid = 1'b0;
  endtask

  // Called at posedge+1 of cycle 'start'; returns at the negedge of the
  // first cycle with out_valid, reporting that cycle's index.
  task automatic wait_out(input int start, output int lat);
    lat = start;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; key_wr_en = 1'b0; key_wr_addr = 4'd0; key_wr_data = '0;
    key_length = 2'b00; in_valid = 1'b0; in_data = '0; in_encrypt = 1'b0;
    out_ready = 1'b1; stall = 1'b0; force_en = 1'b0; force_val = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_wr_err", key_wr_err, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_data", core_data, 128'h0);
    chk("rst_round_key", core_round_key, 128'h0);
    sync();

    // Key entry i holds a single bit i, so the result exposes which rounds ran.
    for (int i = 0; i < 15; i++) kw(4'(i), 128'(1) << i);

    // AES-128 encrypt: 0 ^ (bits 0..10)
    send(128'h0, 1'b1, 2'b00);
    wait_out(1, lat);
    chk("aes128_latency", 128'(lat), 128'd14);
    chk("aes128_data", out_data, 128'h7FF);
    sync();

    // AES-256 decrypt: ~(FFFF0000 ^ 7FFF)
    send(128'hFFFF0000, 1'b0, 2'b11);
    wait_out(1, lat);
    chk("aes256_latency", 128'(lat), 128'd18);
    chk("aes256_data", out_data, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h00008000});
    sync();

    // AES-192 encrypt: 1 ^ 1FFF
    send(128'h1, 1'b1, 2'b10);
    wait_out(1, lat);
    chk("aes192_latency", 128'(lat), 128'd16);
    chk("aes192_data", out_data, 128'h1FFE);
    sync();

    // key_length 01 behaves as AES-128: 123 ^ 7FF
    send(128'h123, 1'b1, 2'b01);
    wait_out(1, lat);
    chk("kl01_latency", 128'(lat), 128'd14);
    chk("kl01_data", out_data, 128'h6DC);
    sync();

    // Key write in cycle 5 of a block is dropped and flagged
    send(128'h0, 1'b1, 2'b00);
    repeat (4) sync();
    kw(4'd3, 128'hDEAD);
    wait_out(6, lat);
    chk("busywr_latency", 128'(lat), 128'd14);
    chk("busywr_data", out_data, 128'h7FF);
    chk("busywr_err", key_wr_err, 1'b1);
    sync();

    // Round-key read: entry 3 unchanged, index 15 reads zero
    force_en  = 1'b1;
    force_val = 4'd3;
    @(negedge clk);
    chk("rk_entry3", core_round_key, 128'h8);
    force_val = 4'd15;
    #1 chk("rk_index15", core_round_key, 128'h0);
    sync();
    force_en = 1'b0;

    // Key write and accept in the same cycle: block sees the new entry 0
    key_wr_en   = 1'b1;
    key_wr_addr = 4'd0;
    key_wr_data = 128'hA5;
    send(128'h0, 1'b1, 2'b00);
    key_wr_en = 1'b0;
    wait_out(1, lat);
    chk("simulwr_data", out_data, 128'h75B);
    sync();
    kw(4'd0, 128'h1);

    // Backpressure: result held for 5 cycles, then drain and accept together
    out_ready = 1'b0;
    send(128'h5A, 1'b1, 2'b00);
    wait_out(1, lat);
    chk("bp_data", out_data, 128'h7A5);
    sync();
    in_valid   = 1'b1;
    in_data    = 128'h3C;
    in_encrypt = 1'b1;
    key_length = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, 128'h7A5);
      chk("bp_hold_ready", in_ready, 1'b0);
      sync();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_ready", in_ready, 1'b1);
    chk("bp_xfer_valid", out_valid, 1'b1);
    sync();
    in_valid = 1'b0;
    wait_out(1, lat);
    chk("bp_next_latency", 128'(lat), 128'd14);
    chk("bp_next_data", out_data, 128'h7C3);
    sync();

    // Reset in the middle of a block drops it
    send(128'h0, 1'b1, 2'b00);
    repeat (3) sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (20) @(negedge clk);
    chk("midrst_no_out", out_valid, 1'b0);
    sync();

`ifdef AES_SEQ_TIMEOUT_EN
    // Stalled core: abort after TO RUN cycles, back in IDLE at cycle TO+2
    stall = 1'b1;
    send(128'h0, 1'b1, 2'b00);
    lat = 1;
    @(negedge clk);
    while (busy && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    chk("to_idle_cycle", 128'(lat), 128'(TO + 2));
    chk("to_err", timeout_err, 1'b1);
    chk("to_in_ready", in_ready, 1'b1);
    chk("to_no_out", out_valid, 1'b0);
    sync();
    stall = 1'b0;
    repeat (3) sync();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
